// File: rtl/pipe_shifter.sv
// rtl/pipe_shifter.sv - log2(WIDTH)-stage pipelined barrel shifter (SLL/SRL/SRA/ROR)
// with a valid/ready handshake on both ports and a whole-pipe stall.
module pipe_shifter #(
  parameter int WIDTH = 32,
  parameter int AW    = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AW-1:0]    in_amt,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero
);

  localparam int L = AW;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;

  logic [WIDTH-1:0] data_q  [L];
  logic [WIDTH-1:0] data_d  [L];
  logic             valid_q [L];
  logic             valid_d [L];
  logic [1:0]       op_q    [L-1];
  logic [1:0]       op_d    [L-1];
  logic             fill_q  [L-1];
  logic             fill_d  [L-1];
  logic [AW-1:0]    amt_q   [L-1];
  logic [AW-1:0]    amt_d   [L-1];
  logic             out_zero_q;

  logic stall;
  logic accept;
  logic in_fill;

  assign stall    = valid_q[L-1] & ~out_ready;
  assign in_ready = ~stall;
  assign accept   = in_valid & in_ready;
  // Fill is latched once so later stages never re-derive it from shifted data.
  assign in_fill  = (in_op == OP_SRA) & in_data[WIDTH-1];

  function automatic logic [WIDTH-1:0] shift_by(
    input logic [WIDTH-1:0] d,
    input logic [1:0]       op,
    input logic             fill,
    input int               k
  );
    logic [WIDTH-1:0] mask;
    mask = ~({WIDTH{1'b1}} >> k);
    case (op)
      OP_SLL:  shift_by = d << k;
      OP_SRL:  shift_by = d >> k;
      OP_SRA:  shift_by = (d >> k) | (fill ? mask : '0);
      default: shift_by = (d >> k) | (d << (WIDTH - k));
    endcase
  endfunction

  for (genvar s = 0; s < L; s++) begin : g_stage
    localparam int K = 1 << (L - 1 - s);

    logic [WIDTH-1:0] src_data;
    logic [1:0]       src_op;
    logic             src_fill;
    logic             src_bit;
    logic             src_valid;

    if (s == 0) begin : g_head
      assign src_data  = in_data;
      assign src_op    = in_op;
      assign src_fill  = in_fill;
      assign src_bit   = in_amt[L-1];
      assign src_valid = accept;
      assign amt_d[0]  = in_amt;
    end else begin : g_tail
      assign src_data  = data_q[s-1];
      assign src_op    = op_q[s-1];
      assign src_fill  = fill_q[s-1];
      assign src_bit   = amt_q[s-1][L-1-s];
      assign src_valid = valid_q[s-1];
      if (s < L - 1) begin : g_amt
        assign amt_d[s] = amt_q[s-1];
      end
    end

    assign data_d[s]  = src_bit ? shift_by(src_data, src_op, src_fill, K) : src_data;
    assign valid_d[s] = src_valid;

    if (s < L - 1) begin : g_ctrl
      assign op_d[s]   = src_op;
      assign fill_d[s] = src_fill;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < L; i++) begin
        data_q[i]  <= '0;
        valid_q[i] <= 1'b0;
      end
      for (int i = 0; i < L - 1; i++) begin
        op_q[i]   <= '0;
        fill_q[i] <= 1'b0;
        amt_q[i]  <= '0;
      end
      out_zero_q <= 1'b1;
    end else if (!stall) begin
      for (int i = 0; i < L; i++) begin
        data_q[i]  <= data_d[i];
        valid_q[i] <= valid_d[i];
      end
      for (int i = 0; i < L - 1; i++) begin
        op_q[i]   <= op_d[i];
        fill_q[i] <= fill_d[i];
        amt_q[i]  <= amt_d[i];
      end
      out_zero_q <= ~|data_d[L-1];
    end
  end

  assign out_valid = valid_q[L-1];
  assign out_data  = data_q[L-1];
  assign out_zero  = out_zero_q;

endmodule

// File: tb/tb_pipe_shifter.sv
// tb/tb_pipe_shifter.sv - scoreboard bench for pipe_shifter (WIDTH=32 and WIDTH=8 instances)
module tb_pipe_shifter;

  logic        clk = 1'b0;
  logic        rst;

  logic        in_valid, in_ready, out_valid, out_ready, out_zero;
  logic [31:0] in_data, out_data;
  logic [4:0]  in_amt;
  logic [1:0]  in_op;

  logic        in_valid8, in_ready8, out_valid8, out_ready8, out_zero8;
  logic [7:0]  in_data8, out_data8;
  logic [2:0]  in_amt8;
  logic [1:0]  in_op8;

  int errors = 0;
  int checks = 0;
  int pop_cnt = 0;
  int run_len = 0;
  int max_run = 0;

  logic [32:0] exp_q[$];

  always #5 clk = ~clk;

  pipe_shifter #(.WIDTH(32)) dut (
    .clock(clk), .reset(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_amt(in_amt), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_zero(out_zero)
  );

  pipe_shifter #(.WIDTH(8)) dut8 (
    .clock(clk), .reset(rst),
    .in_valid(in_valid8), .in_ready(in_ready8), .in_data(in_data8), .in_amt(in_amt8), .in_op(in_op8),
    .out_valid(out_valid8), .out_ready(out_ready8), .out_data(out_data8), .out_zero(out_zero8)
  );

  function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic [4:0] a, input logic [1:0] op);
    logic [63:0] dd;
    dd = {d, d};
    case (op)
      2'b00:   return d << a;
      2'b01:   return d >> a;
      2'b10:   return $signed(d) >>> a;
      default: begin
        dd = dd >> a;
        return dd[31:0];
      end
    endcase
  endfunction

  // Scoreboard consumer: every handshaken result is compared against the queue head.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      logic [32:0] e;
      run_len++;
      if (run_len > max_run) max_run = run_len;
      pop_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected got data=%h with empty queue", out_data);
      end else begin
        e = exp_q.pop_front();
        if (out_data !== e[31:0]) begin
          errors++;
          $display("FAIL sb_data got %h exp %h", out_data, e[31:0]);
        end
        checks++;
        if (out_zero !== e[32]) begin
          errors++;
          $display("FAIL sb_zero got %b exp %b (data exp %h)", out_zero, e[32], e[31:0]);
        end
      end
    end else begin
      run_len = 0;
    end
  end

  task automatic push_op(input logic [31:0] d, input logic [4:0] a, input logic [1:0] op);
    logic [31:0] r;
    bit done;
    r = ref_shift(d, a, op);
    done = 0;
    @(posedge clk); #2;
    in_valid = 1'b1; in_data = d; in_amt = a; in_op = op;
    for (int n = 0; n < 50 && !done; n++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back({(r == 32'h0), r});
        done = 1;
      end else begin
        @(posedge clk); #2;
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL push_accept got in_ready=0 for 50 cycles exp accept");
    end
  endtask

  task automatic measure_latency(output int lat);
    lat = -1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #2;
      in_valid = 1'b0;
      @(negedge clk);
      if (out_valid) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic drain();
    @(posedge clk); #2;
    in_valid = 1'b0;
    for (int n = 0; n < 60 && exp_q.size() != 0; n++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending exp 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks += 5;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", out_valid); end
    if (out_data !== 32'h0) begin errors++; $display("FAIL rst_data got %h exp 0", out_data); end
    if (out_zero !== 1'b1) begin errors++; $display("FAIL rst_zero got %b exp 1", out_zero); end
    if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b exp 1", in_ready); end
    if (out_valid8 !== 1'b0) begin errors++; $display("FAIL rst_valid8 got %b exp 0", out_valid8); end
    @(posedge clk); #2;
    rst = 1'b0;
    @(negedge clk);
    checks += 2;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL post_rst_in_ready got %b exp 1", in_ready); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL post_rst_valid got %b exp 0", out_valid); end
  endtask

  task automatic test_latency();
    int lat;
    push_op(32'h8000_0000, 5'd4, 2'b10);
    measure_latency(lat);
    checks++;
    if (lat != 5) begin errors++; $display("FAIL lat_sra got %0d exp 5", lat); end
    drain();
    push_op(32'h8000_0000, 5'd4, 2'b01);
    measure_latency(lat);
    checks++;
    if (lat != 5) begin errors++; $display("FAIL lat_srl got %0d exp 5", lat); end
    drain();
  endtask

  task automatic test_amt_edges();
    push_op(32'h0000_0001, 5'd1,  2'b11);
    push_op(32'h0000_0001, 5'd31, 2'b00);
    push_op(32'h8000_0000, 5'd31, 2'b01);
    for (int op = 0; op < 4; op++) push_op(32'hC3A5_5A3C, 5'd0, op[1:0]);
    drain();
  endtask

  task automatic test_back_to_back();
    logic [31:0] d [8];
    logic [4:0]  a [8];
    logic [1:0]  o [8];
    int pops0;
    d = '{32'hFFFF_FFFF, 32'h0000_0001, 32'h8000_0000, 32'h1234_5678,
          32'h0000_ABCD, 32'h7FFF_FFFF, 32'hF000_0001, 32'hFFFF_FFFF};
    a = '{5'd31, 5'd1, 5'd4, 5'd8, 5'd16, 5'd31, 5'd31, 5'd7};
    o = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 2'b10, 2'b11, 2'b01};
    max_run = 0;
    pops0 = pop_cnt;
    for (int i = 0; i < 8; i++) push_op(d[i], a[i], o[i]);
    drain();
    @(negedge clk);
    checks += 2;
    if (max_run != 8) begin errors++; $display("FAIL b2b_run got %0d exp 8", max_run); end
    if (pop_cnt - pops0 != 8) begin errors++; $display("FAIL b2b_count got %0d exp 8", pop_cnt - pops0); end
  endtask

  task automatic test_backpressure();
    logic [31:0] held;
    logic        held_z;
    logic [31:0] r6;
    for (int i = 0; i < 5; i++) push_op(32'h0101_0101 << i, 5'(i + 3), 2'(i));
    r6 = ref_shift(32'hA5A5_0F0F, 5'd9, 2'b11);
    @(posedge clk); #2;
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'hA5A5_0F0F; in_amt = 5'd9; in_op = 2'b11;
    held = 32'h0; held_z = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (c == 0) begin held = out_data; held_z = out_zero; end
      checks += 4;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready c%0d got %b exp 0", c, in_ready); end
      if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid c%0d got %b exp 1", c, out_valid); end
      if (out_data !== held) begin errors++; $display("FAIL bp_hold c%0d got %h exp %h", c, out_data, held); end
      if (out_zero !== held_z) begin errors++; $display("FAIL bp_zero c%0d got %b exp %b", c, out_zero, held_z); end
      if (c < 2) begin @(posedge clk); #2; end
    end
    @(posedge clk); #2;
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release got in_ready=%b exp 1", in_ready);
    end else begin
      exp_q.push_back({(r6 == 32'h0), r6});
    end
    drain();
  endtask

  task automatic test_reset_midflight();
    int lat;
    int stale;
    push_op(32'h1111_1111, 5'd1, 2'b00);
    push_op(32'h2222_2222, 5'd2, 2'b01);
    push_op(32'h3333_3333, 5'd3, 2'b11);
    @(posedge clk); #2;
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    checks += 3;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got %b exp 0", out_valid); end
    if (out_data !== 32'h0) begin errors++; $display("FAIL mid_rst_data got %h exp 0", out_data); end
    if (out_zero !== 1'b1) begin errors++; $display("FAIL mid_rst_zero got %b exp 1", out_zero); end
    @(posedge clk); #2;
    rst = 1'b0;
    exp_q.delete();
    stale = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    checks++;
    if (stale != 0) begin errors++; $display("FAIL mid_rst_stale got %0d valid cycles exp 0", stale); end
    push_op(32'h8000_0000, 5'd31, 2'b01);
    measure_latency(lat);
    checks++;
    if (lat != 5) begin errors++; $display("FAIL mid_rst_lat got %0d exp 5", lat); end
    drain();
  endtask

  task automatic test_width8();
    logic [7:0] vd [2];
    logic [2:0] va [2];
    logic [1:0] vo [2];
    logic [7:0] ve [2];
    int lat;
    vd = '{8'h90, 8'h81};
    va = '{3'd3, 3'd4};
    vo = '{2'b10, 2'b11};
    ve = '{8'hF2, 8'h18};
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #2;
      in_valid8 = 1'b1; in_data8 = vd[i]; in_amt8 = va[i]; in_op8 = vo[i];
      lat = -1;
      for (int n = 1; n <= 10; n++) begin
        @(posedge clk); #2;
        in_valid8 = 1'b0;
        @(negedge clk);
        if (out_valid8) begin lat = n; break; end
      end
      checks += 3;
      if (lat != 3) begin errors++; $display("FAIL w8_lat%0d got %0d exp 3", i, lat); end
      if (out_data8 !== ve[i]) begin errors++; $display("FAIL w8_data%0d got %h exp %h", i, out_data8, ve[i]); end
      if (out_zero8 !== 1'b0) begin errors++; $display("FAIL w8_zero%0d got %b exp 0", i, out_zero8); end
      @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_data = '0; in_amt = '0; in_op = '0; out_ready = 1'b1;
    in_valid8 = 1'b0; in_data8 = '0; in_amt8 = '0; in_op8 = '0; out_ready8 = 1'b1;
    test_reset();
    test_latency();
    test_amt_edges();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    test_width8();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1);
  end

endmodule

// File: doc/pipe_shifter.md
# pipe_shifter

Parametrised, pipelined barrel shifter supporting logical left, logical right, arithmetic right and rotate-right on a WIDTH-bit operand. It uses log2(WIDTH) registered stages, one per shift-amount bit, and a valid/ready handshake on both ports. It sits between the register-read stage and writeback in the ALU datapath. It is also the drop-in unit for any block needing a throughput-of-one shifter at high clock rate.

## Interface
Parameters:
- WIDTH, 32, operand width. Must be a power of two, ≥ 8.
- AW, $clog2(WIDTH), shift-amount width and pipeline depth L. Derived; do not override.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand/op/amt valid.
- in_ready  out  1  shifter can accept this cycle.
- in_data  in  WIDTH  operand.
- in_amt  in  AW  shift amount, 0..WIDTH-1.
- in_op  in  2  00 SLL, 01 SRL, 10 SRA, 11 ROR.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_data  out  WIDTH  shifted result.
- out_zero  out  1  out_data == 0.

## Operation
- Pipeline: L register stages S0..S(L-1). Each stage holds data, the remaining amt bits, op, the fill bit, and valid.
- Stage order:
  - S0 is loaded on input accept and applies shift 2^(L-1) when in_amt[L-1] is set.
  - Each following stage applies the next lower power of two.
  - S(L-1) applies shift 1 and drives out_data and out_valid.
- Fill bit:
  - Captured once at accept. Value is in_data[WIDTH-1] for SRA, 0 otherwise.
  - Carried down the pipe; every stage fills with this captured bit, never with a recomputed msb.
- Per-stage transform by k = 2^j when its amt bit is set:
  - SLL: d << k, zero fill.
  - SRL: d >> k, zero fill.
  - SRA: d >> k, upper k bits = fill.
  - ROR: {d[k-1:0], d[WIDTH-1:k]}.
  - Amt bit clear: pass d unchanged.
- out_zero is registered with the last stage and equals the reduction NOR of the last-stage data.
- Handshake:
  - stall = out_valid & ~out_ready.
  - in_ready = ~stall, combinational. No combinational path from in_valid to in_ready.
  - Accept occurs when in_valid & in_ready.
  - When not stalled, every stage advances. S0.valid takes the accept value, so bubbles propagate.
  - When stalled, all stages hold data and valid.
- Data in a stage whose valid = 0 is don't-care, but must not leak to out_data while out_valid = 1.
- Throughput: one operation per cycle when out_ready stays high.

## Timing
- Reset, asynchronous: all stage valids 0, all stage data 0, out_valid 0, out_data 0, out_zero 1. in_ready reads 1 while reset is asserted and after release.
- Latency:
  - An op accepted at rising edge N has out_valid = 1 after edge N+L-1 completes, i.e. visible in cycle N+L-1.
  - Each stall cycle adds one cycle.
  - For WIDTH=32, L=5: result visible in the 5th cycle counting the accept cycle as 1.
- Output hold: out_data, out_zero and out_valid are stable while out_valid & ~out_ready.
- Full pipe with a stall: no accept is possible. An in_valid held through the stall is accepted on the first cycle out_ready = 1.
- Simultaneous accept and output consume in the same cycle: both occur and the pipe shifts by one.
- in_amt = 0: result equals in_data for all ops; for ROR it is unchanged.
- Reset asserted mid-operation: all in-flight ops are discarded immediately. No stale out_valid after release.

## Test plan
- WIDTH=32, SRA 0x8000_0000 amt 4 → 0xF800_0000. SRL same → 0x0800_0000. Both appear 5 cycles after accept, out_zero = 0.
- ROR 0x0000_0001 amt 1 → 0x8000_0000. SLL 0x0000_0001 amt 31 → 0x8000_0000. SRL 0x8000_0000 amt 31 → 0x0000_0001 with amt 0 on every op → unchanged.
- Back-to-back stream of 8 mixed ops with out_ready = 1 → 8 consecutive out_valid cycles, results in order. SLL 0xFFFF_FFFF amt 31 gives 0x8000_0000. SRL 0x1 amt 1 gives out_zero = 1.
- Backpressure: out_ready low for 3 cycles with the pipe full → in_ready = 0, out_data held, no op lost or duplicated after release.
- Reset asserted for 1 cycle with 3 ops in flight → out_valid = 0, out_data = 0, out_zero = 1. The next accepted op emerges alone after L cycles.
- WIDTH=8 instance, L=3: SRA 0x90 amt 3 → 0xF2. ROR 0x81 amt 4 → 0x18. Latency 3 cycles.
